// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD up/down counter.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  function automatic logic is_bcd(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle between the counter and its driver.
interface bcd_updown_counter_if #(parameter int DIGITS = 2);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  tc;
  logic                  wrap;
  logic                  load_err;

  modport master (output en, up, load, load_val, input bcd_out, tc, wrap, load_err);
  modport slave  (input en, up, load, load_val, output bcd_out, tc, wrap, load_err);
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register: load, or step by +/-1 with 9<->0 roll.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t q,
  output logic       is_max,
  output logic       is_min
);
  assign is_max = (q == BCD_MAX);
  assign is_min = (q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= load_d;
    else if (step) begin
      if (up) q <= is_max ? 4'd0 : q + 4'd1;
      else    q <= is_min ? BCD_MAX : q - 4'd1;
    end
  end
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with validated parallel load.
// Build option: BCD_SATURATE_EN holds at the end of range instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_updown_counter_if.slave   bus
);
  logic [DIGITS-1:0][DIGIT_W-1:0] q, ld;
  logic [DIGITS-1:0]              is_max, is_min, step;
  logic [DIGITS:0]                chain;
  logic                           ld_ok, ld_go, cnt_en, at_end;
  logic                           wrap_r, err_r;

  assign ld = bus.load_val;

  always_comb begin
    ld_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) ld_ok &= is_bcd(ld[i]);
  end

  // chain[i]: every digit below i sits at its terminal value for the current direction
  assign chain[0] = 1'b1;
  assign at_end   = chain[DIGITS];

`ifdef BCD_SATURATE_EN
  assign cnt_en = bus.en & ~bus.load & ~at_end;
`else
  assign cnt_en = bus.en & ~bus.load;
`endif

  assign ld_go = bus.load & ld_ok;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign chain[i+1] = chain[i] & (bus.up ? is_max[i] : is_min[i]);
      assign step[i]    = cnt_en & chain[i];

      bcd_digit u_dig (
        .clk    (clk),
        .rst    (rst),
        .load   (ld_go),
        .load_d (ld[i]),
        .step   (step[i]),
        .up     (bus.up),
        .q      (q[i]),
        .is_max (is_max[i]),
        .is_min (is_min[i])
      );
    end
  endgenerate

  assign bus.tc = bus.en & ~bus.load & at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
`ifdef BCD_SATURATE_EN
      wrap_r <= 1'b0;
`else
      wrap_r <= bus.tc;
`endif
      err_r  <= bus.load & ~ld_ok;
    end
  end

  assign bus.bcd_out  = q;
  assign bus.wrap     = wrap_r;
  assign bus.load_err = err_r;
endmodule
